// File: rtl/bft_pkg.sv
// Shared BFT packet definitions.
// Holds the packet field layout, the reserved control port, the packetizer
// state encoding and a helper that assembles a valid packet from its fields.
// Packet layout: [48] valid | [47:43] leaf | [42:39] port | [38:32] seq | [31:0] payload.
package bft_pkg;

  localparam int PACKET_BITS   = 49;
  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_LEAF_BITS = 5;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;

  localparam int VALID_BIT = PACKET_BITS - 1;
  localparam int LEAF_LSB  = PAYLOAD_BITS + NUM_ADDR_BITS + NUM_PORT_BITS;
  localparam int PORT_LSB  = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int ADDR_LSB  = PAYLOAD_BITS;

  // Port 0 of every leaf carries control traffic (freespace updates).
  localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } pk_state_e;

  // Assemble a valid packet from its fields.
  function automatic logic [PACKET_BITS-1:0] make_packet(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] seq,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    make_packet = {1'b1, leaf, port, seq, payload};
  endfunction

endpackage

// File: rtl/leaf_credit_counter.sv
// Saturating credit counter.
// Counts the free words in the receiver's buffer: decremented once per packet
// sent, incremented by a fixed amount per freespace update, never exceeding
// the buffer depth. Both may happen in the same cycle.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset (count returns to MAX_VAL)
//   dec    in  consume one credit (caller guarantees count != 0)
//   inc    in  return INC_VAL credits
//   count  out current credit count (registered)
//   zero   out count == 0 (registered)
module leaf_credit_counter #(
  parameter int CNT_BITS = 8,
  parameter int MAX_VAL  = 128,
  parameter int INC_VAL  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count,
  output logic                zero
);

  // One extra bit so count + INC_VAL cannot wrap before saturation.
  localparam int SUM_BITS = CNT_BITS + 1;
  localparam logic [SUM_BITS-1:0] MAX_W  = SUM_BITS'(MAX_VAL);
  localparam logic [SUM_BITS-1:0] INC_W  = SUM_BITS'(INC_VAL);
  localparam logic [SUM_BITS-1:0] ONE_W  = SUM_BITS'(1);
  localparam logic [SUM_BITS-1:0] ZERO_W = {SUM_BITS{1'b0}};

  logic [CNT_BITS-1:0] count_r;
  logic                zero_r;
  logic [SUM_BITS-1:0] add_s;
  logic [SUM_BITS-1:0] sub_s;
  logic [SUM_BITS-1:0] sum_s;
  logic [CNT_BITS-1:0] count_s;

  assign add_s = inc ? INC_W : ZERO_W;
  assign sub_s = dec ? ONE_W : ZERO_W;
  assign sum_s = {1'b0, count_r} + add_s - sub_s;

  // Clamp the updated count to the buffer depth.
  always_comb begin
    count_s = sum_s[CNT_BITS-1:0];
    if (sum_s > MAX_W) begin
      count_s = MAX_W[CNT_BITS-1:0];
    end else begin
      count_s = sum_s[CNT_BITS-1:0];
    end
  end

  // Credit and zero-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= MAX_W[CNT_BITS-1:0];
      zero_r  <= 1'b0;
    end else begin
      count_r <= count_s;
      zero_r  <= (count_s == {CNT_BITS{1'b0}});
    end
  end

  assign count = count_r;
  assign zero  = zero_r;

endmodule

// File: rtl/leaf_out_packetizer.sv
// Leaf output packetizer.
// Wraps each 32-bit word from the user kernel into a BFT packet addressed to a
// fixed leaf/port, spending one receiver-buffer credit per packet. Credits are
// refilled by freespace-update packets arriving on the control port. A packet
// the BFT rejects (resend) is held bit-exact until it is taken.
// Ports:
//   clk                      in   clock
//   reset                    in   synchronous active-high reset
//   din_leaf_user2interface  in   user data word
//   vld_user2interface       in   user word valid
//   ack_interface2user       out  word accepted this cycle (combinational)
//   din_leaf_bft2interface   in   incoming packet (only credit updates used)
//   dout_leaf_interface2bft  out  outgoing packet (registered)
//   resend                   in   BFT rejected the packet presented this cycle
module leaf_out_packetizer
  import bft_pkg::*;
#(
  parameter int                       NUM_BRAM_ADDR_BITS    = 7,
  parameter int                       FREESPACE_UPDATE_SIZE = 64,
  parameter logic [NUM_LEAF_BITS-1:0] DEST_LEAF             = 5'd0,
  parameter logic [NUM_PORT_BITS-1:0] DEST_PORT             = 4'd1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic                    vld_user2interface,
  output logic                    ack_interface2user,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  input  logic                    resend
);

  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_ONE = CREDIT_BITS'(1);
  localparam logic [PACKET_BITS-1:0] PKT_EMPTY  = {PACKET_BITS{1'b0}};

  pk_state_e               state_r;
  pk_state_e               state_s;
  logic [PACKET_BITS-1:0]  dout_r;
  logic [PACKET_BITS-1:0]  dout_s;
  logic [NUM_ADDR_BITS-1:0] seq_r;
  logic [CREDIT_BITS-1:0]  credit_s;
  logic                    credit_zero_s;
  logic                    slot_free_s;
  logic                    hold_s;
  logic                    update_s;
  logic                    accept_s;
  logic                    din_unused_s;

  // Only the valid bit and port field of incoming packets matter here.
  assign din_unused_s = ^{din_leaf_bft2interface[VALID_BIT-1:PORT_LSB+NUM_PORT_BITS],
                          din_leaf_bft2interface[PORT_LSB-1:0]};

  assign update_s = din_leaf_bft2interface[VALID_BIT] &
                    (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT);

  // The output slot can take a new packet when it is empty or its packet is leaving.
  assign hold_s      = dout_r[VALID_BIT] & resend;
  assign slot_free_s = ~hold_s;
  assign accept_s    = ~reset & vld_user2interface & ~credit_zero_s & slot_free_s;

  assign ack_interface2user = accept_s;

  leaf_credit_counter #(
    .CNT_BITS (CREDIT_BITS),
    .MAX_VAL  (2 ** NUM_BRAM_ADDR_BITS),
    .INC_VAL  (FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .dec   (accept_s),
    .inc   (update_s),
    .count (credit_s),
    .zero  (credit_zero_s)
  );

  // Next output packet: new word, held rejected packet, or empty.
  always_comb begin
    dout_s = PKT_EMPTY;
    if (accept_s) begin
      dout_s = make_packet(DEST_LEAF, DEST_PORT, seq_r, din_leaf_user2interface);
    end else if (hold_s) begin
      dout_s = dout_r;
    end else begin
      dout_s = PKT_EMPTY;
    end
  end

  // Next-state logic; STALL is entered when the accepted word spends the last credit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_SEND: begin
        if (accept_s) begin
          if ((credit_s == CREDIT_ONE) && !update_s) begin
            state_s = ST_STALL;
          end else begin
            state_s = ST_SEND;
          end
        end else if (hold_s) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STALL: begin
        // A packet still in flight keeps draining while stalled.
        if (update_s) begin
          if (hold_s) begin
            state_s = ST_SEND;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_STALL;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, output packet and sequence registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      dout_r  <= PKT_EMPTY;
      seq_r   <= 7'd0;
    end else begin
      state_r <= state_s;
      dout_r  <= dout_s;
      if (accept_s) begin
        seq_r <= seq_r + 7'd1;
      end else begin
        seq_r <= seq_r;
      end
    end
  end

  assign dout_leaf_interface2bft = dout_r;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Scoreboard bench for leaf_out_packetizer.
// The driver applies one directed vector per cycle with a hand-chosen expected
// ack and queues the packet expected on dout after the next clock edge; an
// independent monitor pops and compares after every rising edge.
module tb_leaf_out_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din_user = 32'd0;
  logic        vld = 1'b0;
  logic        ack;
  logic [48:0] din_bft = 49'd0;
  logic [48:0] dout;
  logic        resend = 1'b0;

  localparam logic [48:0] UPD      = {1'b1, 5'd0, 4'd0, 7'd0, 32'd0};
  localparam logic [48:0] OTHER    = {1'b1, 5'd3, 4'd2, 7'd5, 32'h0000_1234};
  localparam logic [48:0] INV_CTRL = {1'b0, 5'd0, 4'd0, 7'd0, 32'h0000_FFFF};
  localparam logic [48:0] NONE     = 49'd0;

  always #5 clk = ~clk;

  leaf_out_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din_user),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .din_leaf_bft2interface  (din_bft),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend)
  );

  logic [48:0] exp_q[$];
  logic [48:0] last_exp = 49'd0;
  logic [6:0]  seq_e = 7'd0;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic [48:0] pkt(input logic [6:0] s, input logic [31:0] w);
    return {1'b1, 5'd0, 4'd1, s, w};
  endfunction

  // One cycle: drive inputs, check ack, queue the expected next dout.
  task automatic step(input logic v, input logic [31:0] w, input logic rs,
                      input logic [48:0] d, input logic rst, input logic exp_ack,
                      input string tag);
    logic [48:0] nxt;
    @(negedge clk);
    vld = v; din_user = w; resend = rs; din_bft = d; reset = rst;
    #1;
    n_vec++;
    if (ack !== exp_ack) begin
      n_miss++;
      $display("FAIL ack[%s] t=%0t: got %b want %b", tag, $time, ack, exp_ack);
    end
    if (rst) begin
      nxt = 49'd0;
      seq_e = 7'd0;
    end else if (exp_ack) begin
      nxt = pkt(seq_e, w);
      seq_e = seq_e + 7'd1;
    end else if (last_exp[48] && rs) begin
      nxt = last_exp;
    end else begin
      nxt = 49'd0;
    end
    last_exp = nxt;
    exp_q.push_back(nxt);
  endtask

  // Monitor: compare dout against the scoreboard after every rising edge.
  initial begin
    logic [48:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (dout !== e) begin
          n_miss++;
          $display("FAIL dout t=%0t: got %h want %h", $time, dout, e);
        end
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    step(1'b0, 32'd0, 1'b0, NONE, 1'b1, 1'b0, "rst0");
    step(1'b0, 32'd0, 1'b0, NONE, 1'b1, 1'b0, "rst1");

    // Four back-to-back words, seq 0..3 (credit 124 afterwards)
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'hA0A0_0000 + i, 1'b0, NONE, 1'b0, 1'b1, "t1_send");

    // Resend holds the last packet for three cycles, then it drains
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'hB0B0_0000, 1'b1, NONE, 1'b0, 1'b0, "t2_hold");
    step(1'b0, 32'd0, 1'b0, NONE, 1'b0, 1'b0, "t2_drain");

    // Spend the remaining 124 credits; seq wraps to 0, then no ack
    for (int i = 0; i < 124; i++)
      step(1'b1, 32'hC000_0000 + i, 1'b0, NONE, 1'b0, 1'b1, "t3_send");
    step(1'b1, 32'hCCCC_CCCC, 1'b0, NONE, 1'b0, 1'b0, "t3_nocredit");
    step(1'b1, 32'hCCCC_CCCD, 1'b0, NONE, 1'b0, 1'b0, "t3_stall");

    // Update while stalled: no ack that cycle, ack next cycle (credit 64 -> 63)
    step(1'b1, 32'hD0D0_0000, 1'b0, UPD, 1'b0, 1'b0, "t4_upd");
    step(1'b1, 32'hD0D0_0001, 1'b0, NONE, 1'b0, 1'b1, "t4_resume");

    // 63 + 64 = 127; spend 27 -> 100; update saturates at 128
    step(1'b0, 32'd0, 1'b0, UPD, 1'b0, 1'b0, "t5_upd");
    for (int i = 0; i < 27; i++)
      step(1'b1, 32'h5500_0000 + i, 1'b0, NONE, 1'b0, 1'b1, "t5_to100");
    step(1'b0, 32'd0, 1'b0, UPD, 1'b0, 1'b0, "t5_sat");
    // 128 - 118 = 10; same-cycle accept + update -> 73
    for (int i = 0; i < 118; i++)
      step(1'b1, 32'h5A00_0000 + i, 1'b0, NONE, 1'b0, 1'b1, "t5_to10");
    step(1'b1, 32'h5BBB_0000, 1'b0, UPD, 1'b0, 1'b1, "t5_both");
    for (int i = 0; i < 73; i++)
      step(1'b1, 32'h5C00_0000 + i, 1'b0, NONE, 1'b0, 1'b1, "t5_73");
    step(1'b1, 32'h5DDD_DDDD, 1'b0, NONE, 1'b0, 1'b0, "t5_empty");

    // Reset while a packet is held by resend
    step(1'b0, 32'd0, 1'b0, UPD, 1'b0, 1'b0, "t6_upd");
    step(1'b1, 32'hE0E0_0000, 1'b0, NONE, 1'b0, 1'b1, "t6_send");
    step(1'b1, 32'hE0E0_0001, 1'b1, NONE, 1'b1, 1'b0, "t6_rst");
    step(1'b0, 32'd0, 1'b0, NONE, 1'b0, 1'b0, "t6_idle");
    step(1'b1, 32'hF0F0_0000, 1'b0, NONE, 1'b0, 1'b1, "t6_seq0");

    // Non-control and invalid packets must not refill credit (127 remain)
    step(1'b0, 32'd0, 1'b0, OTHER, 1'b0, 1'b0, "t6_other");
    step(1'b0, 32'd0, 1'b0, INV_CTRL, 1'b0, 1'b0, "t6_invalid");
    for (int i = 0; i < 127; i++)
      step(1'b1, 32'hF100_0000 + i, 1'b0, NONE, 1'b0, 1'b1, "t6_fill");
    step(1'b1, 32'hF2F2_F2F2, 1'b0, NONE, 1'b0, 1'b0, "t6_last");
    step(1'b0, 32'd0, 1'b0, NONE, 1'b0, 1'b0, "end");

    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected packets left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
